// File: rtl/led_row_serializer_if.sv
// Pixel-path bundle between the show-ahead FIFO read port, the row serializer
// and the LED driver pins.
interface led_row_serializer_if #(
  parameter int unsigned DW = 12
);
  logic          start;
  logic [DW-1:0] fifo_dout;
  logic          fifo_valid;
  logic          fifo_re;
  logic          led_sclk;
  logic          led_sdi;
  logic          led_le;
  logic          busy;
  logic          row_done;

  modport master (
    output start, fifo_dout, fifo_valid,
    input  fifo_re, led_sclk, led_sdi, led_le, busy, row_done
  );

  modport slave (
    input  start, fifo_dout, fifo_valid,
    output fifo_re, led_sclk, led_sdi, led_le, busy, row_done
  );
endinterface

// File: rtl/led_row_serializer.sv
// Drains one row of grayscale words from a show-ahead FIFO per start pulse,
// shifts each MSB-first on sclk/sdi, then pulses the row latch.
module led_row_serializer #(
  parameter int unsigned DW          = 12,
  parameter int unsigned PIX_PER_ROW = 64,
  parameter int unsigned SCLK_DIV    = 2,
  parameter int unsigned LE_WIDTH    = 2
) (
  input  logic                clkr,
  input  logic                rst,
  led_row_serializer_if.slave bus
);

  localparam int unsigned PIX_W = (PIX_PER_ROW > 1) ? $clog2(PIX_PER_ROW) : 1;
  localparam int unsigned BIT_W = $clog2(DW);
  localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned LE_W  = (LE_WIDTH > 1) ? $clog2(LE_WIDTH) : 1;
  localparam int unsigned SR_W  = DW - 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_PER_ROW - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DW - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [LE_W-1:0]  LE_LAST  = LE_W'(LE_WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  logic [1:0]       state_q,    state_d;
  logic [PIX_W-1:0] pix_cnt_q,  pix_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
  logic [LE_W-1:0]  le_cnt_q,   le_cnt_d;
  // The MSB goes straight to sdi on load, so only the remaining bits are kept.
  logic [SR_W-1:0]  shreg_q,    shreg_d;
  logic             sclk_q,     sclk_d;
  logic             sdi_q,      sdi_d;
  logic             le_q,       le_d;
  logic             busy_q,     busy_d;
  logic             row_done_q, row_done_d;

  // Next-state and output computation.
  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    le_cnt_d   = le_cnt_q;
    shreg_d    = shreg_q;
    sclk_d     = sclk_q;
    sdi_d      = sdi_q;
    le_d       = le_q;
    row_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_LOAD;
          pix_cnt_d = '0;
        end
      end

      S_LOAD: begin
        if (bus.fifo_valid) begin
          shreg_d   = bus.fifo_dout[SR_W-1:0];
          sdi_d     = bus.fifo_dout[DW-1];
          bit_cnt_d = '0;
          div_cnt_d = '0;
          sclk_d    = 1'b0;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of the high phase: advance to the next bit.
            sclk_d    = 1'b0;
            sdi_d     = shreg_q[SR_W-1];
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_LAST) begin
              if (pix_cnt_q == PIX_LAST) begin
                state_d  = S_LATCH;
                le_d     = 1'b1;
                le_cnt_d = '0;
              end else begin
                pix_cnt_d = pix_cnt_q + PIX_W'(1);
                state_d   = S_LOAD;
              end
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      S_LATCH: begin
        if (le_cnt_q == LE_LAST) begin
          le_d       = 1'b0;
          row_done_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          le_cnt_d = le_cnt_q + LE_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clkr or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pix_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      le_cnt_q   <= '0;
      shreg_q    <= '0;
      sclk_q     <= 1'b0;
      sdi_q      <= 1'b0;
      le_q       <= 1'b0;
      busy_q     <= 1'b0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      le_cnt_q   <= le_cnt_d;
      shreg_q    <= shreg_d;
      sclk_q     <= sclk_d;
      sdi_q      <= sdi_d;
      le_q       <= le_d;
      busy_q     <= busy_d;
      row_done_q <= row_done_d;
    end
  end

  // Read strobe is combinational so the word is consumed in the cycle it is captured.
  assign bus.fifo_re  = (state_q == S_LOAD) && bus.fifo_valid && !rst;
  assign bus.led_sclk = sclk_q;
  assign bus.led_sdi  = sdi_q;
  assign bus.led_le   = le_q;
  assign bus.busy     = busy_q;
  assign bus.row_done = row_done_q;

endmodule

// File: tb/tb_led_row_serializer.sv
// Scoreboard bench: two serializer instances (single-pixel and default row)
// fed from modelled show-ahead FIFOs; a negedge monitor reassembles words.
module tb_led_row_serializer;

  localparam int unsigned DW    = 12;
  localparam int unsigned A_PIX = 1;
  localparam int unsigned A_DIV = 1;
  localparam int unsigned A_LE  = 2;
  localparam int unsigned B_PIX = 64;
  localparam int unsigned B_DIV = 2;
  localparam int unsigned B_LE  = 2;
  localparam int A_ROW_LEN = 27;    // 1*(1+2*12*1)+2
  localparam int B_ROW_LEN = 3138;  // 64*(1+2*12*2)+2

  logic clkr = 1'b0;
  logic rst_a, rst_b;
  always #5 clkr = ~clkr;

  led_row_serializer_if #(.DW(DW)) ifa ();
  led_row_serializer_if #(.DW(DW)) ifb ();

  led_row_serializer #(.DW(DW), .PIX_PER_ROW(A_PIX), .SCLK_DIV(A_DIV), .LE_WIDTH(A_LE))
    dut_a (.clkr(clkr), .rst(rst_a), .bus(ifa.slave));
  led_row_serializer #(.DW(DW), .PIX_PER_ROW(B_PIX), .SCLK_DIV(B_DIV), .LE_WIDTH(B_LE))
    dut_b (.clkr(clkr), .rst(rst_b), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clkr) cyc <= cyc + 1;

  // FIFO contents (written by stimulus) and expected output words (scoreboard).
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [512];
  int wr_a = 0;
  int wr_b = 0;
  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];

  // Monitor state, per instance.
  int re_cnt [2] = '{0, 0};
  int words  [2] = '{0, 0};
  int disc   [2] = '{0, 0};
  int rows   [2] = '{0, 0};
  int bits   [2] = '{0, 0};
  int le_len [2] = '{0, 0};
  logic [DW-1:0] acc [2];
  logic prev_sclk [2] = '{1'b0, 1'b0};
  logic prev_le   [2] = '{1'b0, 1'b0};
  int le_sclk_bad = 0;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clkr);
    #2;
  endtask

  task automatic push(input int d, input logic [DW-1:0] w);
    if (d == 0) begin
      mem_a[wr_a] = w; wr_a++; exp_a.push_back(w);
    end else begin
      mem_b[wr_b] = w; wr_b++; exp_b.push_back(w);
    end
  endtask

  task automatic mon(input int d, input logic r, input logic sclk, input logic sdi,
                     input logic le, input logic re, input logic busy, input logic rd,
                     input int le_w);
    string pfx = (d == 0) ? "a" : "b";
    logic [DW-1:0] e;
    int n;
    bit have;
    if (r) begin
      // Words consumed but not fully shifted are discarded by reset.
      n = re_cnt[d] - words[d] - disc[d];
      for (int i = 0; i < n; i++) begin
        if (d == 0 && exp_a.size() > 0) void'(exp_a.pop_front());
        if (d == 1 && exp_b.size() > 0) void'(exp_b.pop_front());
      end
      disc[d] += n;
      bits[d] = 0;
      acc[d] = '0;
      prev_sclk[d] = 1'b0;
      prev_le[d] = 1'b0;
      le_len[d] = 0;
      return;
    end
    if (re) re_cnt[d]++;
    if (le && sclk) le_sclk_bad++;
    if (sclk && !prev_sclk[d]) begin
      acc[d] = {acc[d][DW-2:0], sdi};
      bits[d]++;
      if (bits[d] == DW) begin
        bits[d] = 0;
        words[d]++;
        have = (d == 0) ? (exp_a.size() > 0) : (exp_b.size() > 0);
        check({pfx, "_word_expected"}, longint'(have), 1);
        if (have) begin
          if (d == 0) e = exp_a.pop_front();
          else        e = exp_b.pop_front();
          check({pfx, "_word"}, acc[d], e);
        end
      end
    end
    if (!le && prev_le[d]) begin
      check({pfx, "_le_width"}, le_len[d], le_w);
      le_len[d] = 0;
    end
    if (le) le_len[d]++;
    if (rd) begin
      rows[d]++;
      check({pfx, "_row_done_busy"}, busy, 0);
    end
    prev_sclk[d] = sclk;
    prev_le[d] = le;
  endtask

  always @(negedge clkr) begin
    mon(0, rst_a, ifa.led_sclk, ifa.led_sdi, ifa.led_le, ifa.fifo_re, ifa.busy, ifa.row_done, A_LE);
    mon(1, rst_b, ifb.led_sclk, ifb.led_sdi, ifb.led_le, ifb.fifo_re, ifb.busy, ifb.row_done, B_LE);
  end

  // Show-ahead FIFO model: the head advances after each observed read strobe.
  always @(posedge clkr) begin
    #1;
    ifa.fifo_valid = (wr_a > re_cnt[0]);
    ifa.fifo_dout  = (wr_a > re_cnt[0]) ? mem_a[re_cnt[0]] : '0;
    ifb.fifo_valid = (wr_b > re_cnt[1]);
    ifb.fifo_dout  = (wr_b > re_cnt[1]) ? mem_b[re_cnt[1]] : '0;
  end

  task automatic wait_rd(input int d, input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound && !ok; n++) begin
      tick();
      ok = (d == 0) ? ifa.row_done : ifb.row_done;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t0, re0, row0, w0, dev;
    logic sdi0;

    rst_a = 1'b1; rst_b = 1'b1;
    ifa.start = 1'b0; ifb.start = 1'b0;
    push(0, 12'hA5C);
    repeat (3) tick();
    check("a_reset_outputs", {ifa.fifo_re, ifa.led_sclk, ifa.led_sdi, ifa.led_le, ifa.busy, ifa.row_done}, 0);
    check("b_reset_outputs", {ifb.fifo_re, ifb.led_sclk, ifb.led_sdi, ifb.led_le, ifb.busy, ifb.row_done}, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) tick();
    check("a_idle_no_read", ifa.fifo_re, 0);

    // Single pixel row.
    ifa.start = 1'b1; tick(); ifa.start = 1'b0;
    check("a_re_at_load", ifa.fifo_re, 1);
    t0 = cyc;
    wait_rd(0, 100, ok);
    check("a_row_done_seen", ok, 1);
    check("a_row_len", cyc - t0, A_ROW_LEN);
    tick();
    check("a_row_done_one_cycle", ifa.row_done, 0);
    check("a_re_count", re_cnt[0], 1);
    check("a_rows", rows[0], 1);
    check("a_words", words[0], 1);
    check("a_partial_bits", bits[0], 0);

    // Full row of 0..63 with start pulses while busy.
    for (int i = 0; i < 64; i++) push(1, 12'(i));
    tick(); ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    check("b1_re_at_load", ifb.fifo_re, 1);
    check("b1_busy_at_load", ifb.busy, 1);
    t0 = cyc; re0 = re_cnt[1]; row0 = rows[1]; dev = 0; ok = 1'b0;
    for (int n = 0; n < 4000 && !ok; n++) begin
      tick();
      ok = ifb.row_done;
      if (!ok) begin
        if (ifb.busy !== 1'b1) dev++;
        ifb.start = (n % 5 == 4);
      end
    end
    ifb.start = 1'b0;
    check("b1_row_done_seen", ok, 1);
    check("b1_row_len", cyc - t0, B_ROW_LEN);
    check("b1_busy_low_cycles", dev, 0);
    repeat (6) tick();
    check("b1_re_count", re_cnt[1] - re0, 64);
    check("b1_one_row", rows[1] - row0, 1);
    check("b1_idle_after", ifb.busy, 0);
    check("b1_exp_left", exp_b.size(), 0);

    // FIFO runs dry after the first word: stall between pixels.
    push(1, 12'h5A3);
    re0 = re_cnt[1]; row0 = rows[1]; w0 = words[1];
    ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    for (int n = 0; n < 200 && words[1] == w0; n++) tick();
    check("b2_first_word_out", words[1] - w0, 1);
    for (int n = 0; n < 10 && ifb.led_sclk; n++) tick();
    sdi0 = ifb.led_sdi; dev = 0;
    repeat (10) begin
      tick();
      if (ifb.led_sclk !== 1'b0 || ifb.led_sdi !== sdi0 || ifb.busy !== 1'b1 || ifb.fifo_re !== 1'b0) dev++;
    end
    check("b2_stall_hold", dev, 0);
    check("b2_re_during_stall", re_cnt[1] - re0, 1);
    for (int i = 0; i < 63; i++) push(1, 12'hFFF - 12'(i * 7));
    wait_rd(1, 4000, ok);
    check("b2_row_done_seen", ok, 1);
    tick();
    check("b2_re_count", re_cnt[1] - re0, 64);
    check("b2_one_row", rows[1] - row0, 1);
    check("b2_exp_left", exp_b.size(), 0);

    // Reset mid-bit during pixel 3, then a fresh row.
    for (int i = 0; i < 64; i++) push(1, 12'h100 + 12'(i * 3));
    re0 = re_cnt[1]; row0 = rows[1]; w0 = words[1];
    ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    for (int n = 0; n < 400 && words[1] < w0 + 3; n++) tick();
    check("b3_reach_pixel3", words[1] - w0, 3);
    repeat (8) tick();
    rst_b = 1'b1;
    #1;
    check("b3_reset_outputs", {ifb.fifo_re, ifb.led_sclk, ifb.led_sdi, ifb.led_le, ifb.busy, ifb.row_done}, 0);
    check("b3_re_before_reset", re_cnt[1] - re0, 4);
    repeat (5) tick();
    check("b3_no_row_done", rows[1] - row0, 0);
    check("b3_no_read_in_reset", re_cnt[1] - re0, 4);
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) push(1, 12'h800 + 12'(i));
    tick(); ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    t0 = cyc;
    wait_rd(1, 4000, ok);
    check("b3_row_done_seen", ok, 1);
    check("b3_row_len", cyc - t0, B_ROW_LEN);
    tick();
    check("b3_re_count", re_cnt[1] - re0, 68);
    check("b3_one_row", rows[1] - row0, 1);
    check("b3_exp_left", exp_b.size(), 0);

    // Back-to-back rows: start in the row_done cycle.
    for (int i = 0; i < 128; i++) push(1, 12'((i * 37) ^ 12'h9C3));
    re0 = re_cnt[1]; row0 = rows[1];
    ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    wait_rd(1, 4000, ok);
    check("b4_row1_done_seen", ok, 1);
    ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    check("b4_re_after_row_done", ifb.fifo_re, 1);
    check("b4_busy_after_row_done", ifb.busy, 1);
    t0 = cyc;
    wait_rd(1, 4000, ok);
    check("b4_row2_done_seen", ok, 1);
    check("b4_row2_len", cyc - t0, B_ROW_LEN);
    repeat (4) tick();
    check("b4_re_count", re_cnt[1] - re0, 128);
    check("b4_two_rows", rows[1] - row0, 2);
    check("b4_exp_left", exp_b.size(), 0);
    check("le_sclk_overlap", le_sclk_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_row_serializer.md
Name: led_row_serializer

Overview:
- Consumer end of the LED pixel path: drains 12-bit grayscale words from the show-ahead (first-word-fall-through) async FIFO read port in the clkr domain.
- Serializes each word MSB-first onto the LED driver shift interface (sclk/sdi).
- Pulses the latch (le) after a full row of pixels has been shifted.
- Sits between the FIFO read side and the LED driver pins; one row per start pulse.

Parameters:
- DW, 12, pixel word width; also the bit count shifted per pixel.
- PIX_PER_ROW, 64, words shifted per row before latching (>=1).
- SCLK_DIV, 2, clkr cycles per sclk half-period (>=1).
- LE_WIDTH, 2, clkr cycles le is held high (>=1).

Ports:
- clkr  in  1  read-side clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle row request; sampled only in IDLE
- fifo_dout  in  DW  show-ahead FIFO data; meaningful when fifo_valid=1
- fifo_valid  in  1  FIFO holds a presented word (inverse of empty)
- fifo_re  out  1  consume presented word; combinational
- led_sclk  out  1  shift clock to driver
- led_sdi  out  1  serial data, MSB first
- led_le  out  1  row latch
- busy  out  1  high in every state except IDLE
- row_done  out  1  one-cycle pulse when a row completes

Behaviour:
- Reset values: all registered outputs 0. State IDLE, counters 0, shift register 0. fifo_re=0 while rst is high.
- State machine: IDLE, LOAD, SHIFT, LATCH.
- IDLE:
  - start=1 -> LOAD, pix_cnt=0.
  - start is ignored in every other state; there is no queuing.
- LOAD:
  - fifo_re = (state==LOAD) & fifo_valid. This is the only source of fifo_re, so at most one pulse per pixel.
  - fifo_valid=1: capture fifo_dout into the shift register, led_sdi <= fifo_dout[DW-1], bit_cnt=0, div_cnt=0, go to SHIFT.
  - fifo_valid=0: stall in LOAD. led_sclk stays 0 and led_sdi holds. No timeout.
- SHIFT, per bit, 2*SCLK_DIV cycles:
  - led_sclk=0 for the first SCLK_DIV cycles, then 1 for SCLK_DIV cycles.
  - led_sdi is stable for the whole bit, so data is valid on the sclk rising edge.
  - At the end of the high phase: shift left, led_sdi <= next MSB, bit_cnt++.
  - After bit DW-1 high phase: led_sclk <= 0.
    - If pix_cnt == PIX_PER_ROW-1 -> LATCH.
    - Else pix_cnt++ -> LOAD.
- LATCH:
  - led_le=1 for exactly LE_WIDTH cycles with led_sclk=0.
  - Then -> IDLE, row_done=1 for the first IDLE cycle, busy=0 in that cycle.
- Latency, unstalled:
  - start sampled at cycle T -> LOAD at T+1 and fifo_re at T+1.
  - First sclk rise at T+2+SCLK_DIV.
  - Row length: PIX_PER_ROW*(1+2*DW*SCLK_DIV) + LE_WIDTH cycles from the LOAD entry.
- Widths:
  - pix_cnt: clog2(PIX_PER_ROW) bits, minimum 1.
  - bit_cnt: clog2(DW) bits.
  - div_cnt: clog2(SCLK_DIV) bits, minimum 1.
  - No counter wraps within a row.
- Boundaries:
  - FIFO empties mid-row: stall in LOAD only, between pixels; never mid-pixel.
  - fifo_valid drops after fifo_re: no effect, data already captured.
  - start in the same cycle as row_done: ignored, since the state is already IDLE? No — it is accepted, because the state is IDLE.
  - Async rst mid-row: immediate return to IDLE with outputs 0, no row_done. The partial row is discarded and no further FIFO words are consumed.

Test Plan:
- Single pixel, PIX_PER_ROW=1, SCLK_DIV=1, LE_WIDTH=2; FIFO presents 12'hA5C, start pulse -> exactly 1 fifo_re, 12 sclk rises with sdi sampled 1,0,1,0,0,1,0,1,1,1,0,0, le high 2 cycles, row_done 1 cycle, total 27 cycles from LOAD.
- Default params, 64 words 0..63 preloaded -> 64 fifo_re pulses, 768 sclk rises, reassembled words equal 0..63 in order, one le pulse of 2 cycles, row length 64*49+2 = 3138 cycles.
- PIX_PER_ROW=2, fifo_valid deasserted 10 cycles after the first word -> FSM held in LOAD, sclk=0, sdi constant for 10 cycles; second word shifts intact; no extra fifo_re.
- start pulses while busy (every 5 cycles) -> ignored; exactly one row shifted and one row_done; busy=1 throughout the row.
- rst asserted mid-bit during pixel 3 -> sclk, sdi, le, busy, row_done and fifo_re all 0 immediately, no row_done. A new start then shifts a full row from the next FIFO word.
- start asserted in the row_done cycle -> the next row begins with LOAD in the following cycle; back-to-back rows with no gap other than LATCH.
